// File: rtl/cfg_streamer.sv
// cfg_streamer
//   Feeds one logic unit's configuration port. Payload bytes from the
//   bitstream loader (valid/ready) are turned into header/payload byte
//   pairs on cfg_out. Every header is generated here, so the loader only
//   supplies payloads, in record order:
//     block records idx = 0 .. NUM_LAYERS*32-1, header {1'b1, idx[6:0]}
//       (idx[6:5] layer, idx[4:2] bit address, idx[1:0] field X/Y/AB/CX)
//     final record, header 8'h7F, payload = output-inversion mask
//   Any cycle that carries neither a header nor a payload drives 8'h00.
//
// Ports
//   clk, rst_n  clock; synchronous active-low reset
//   start       begin a pass (only looked at while idle)
//   abort       end the pass at the next record boundary
//   s_data/s_valid/s_ready  payload source handshake
//   cfg_out     registered byte stream to the unit's cfg_in
//   busy        registered, high while a pass is in progress
//   done        registered, one-cycle pulse when a pass completes
//
// Build option
//   CFG_STREAMER_GAP_EN  when defined, one idle (8'h00) cycle is inserted
//                        after every non-final record.
module cfg_streamer #(
  parameter int NUM_LAYERS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] cfg_out,
  output logic       busy,
  output logic       done
);

  // idx runs one past the last block record; that value is the mask record.
  localparam logic [7:0] MASK_IDX = 8'(NUM_LAYERS * 32);

`ifdef CFG_STREAMER_GAP_EN
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DATA, S_GAP} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DATA} state_e;
`endif

  state_e     state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] pay_q, pay_d;
  logic [7:0] cfg_q, cfg_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       is_mask;
  logic [7:0] header;

  assign is_mask = (idx_q == MASK_IDX);
  assign header  = is_mask ? 8'h7F : {1'b1, idx_q[6:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 8'h00;
      pay_q   <= 8'h00;
      cfg_q   <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pay_q   <= pay_d;
      cfg_q   <= cfg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pay_d   = pay_q;
    cfg_d   = 8'h00;
    done_d  = 1'b0;
    s_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        // abort wins over a simultaneous start
        if (start && !abort) begin
          state_d = S_ISSUE;
          idx_d   = 8'h00;
        end
      end
      S_ISSUE: begin
        // ready is withdrawn under abort so the source never sees a
        // handshake that the block then drops
        s_ready = !abort;
        if (abort) begin
          state_d = S_IDLE;
        end else if (s_valid) begin
          cfg_d   = header;
          pay_d   = s_data;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        // the payload always follows its header, abort or not
        cfg_d = pay_q;
        if (is_mask || abort) begin
          state_d = S_IDLE;
          done_d  = is_mask && !abort;
        end else begin
          idx_d = idx_q + 8'd1;
`ifdef CFG_STREAMER_GAP_EN
          state_d = S_GAP;
`else
          state_d = S_ISSUE;
`endif
        end
      end
`ifdef CFG_STREAMER_GAP_EN
      S_GAP: begin
        state_d = abort ? S_IDLE : S_ISSUE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign cfg_out = cfg_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_cfg_streamer.sv
// Self-checking bench for cfg_streamer. A record-level model predicts the
// byte stream each cycle; directed passes add literal checks on the trace.
module tb_cfg_streamer;
`ifdef CFG_STREAMER_GAP_EN
  localparam int L    = 1;
  localparam int GAPC = 1;
`else
  localparam int L    = 4;
  localparam int GAPC = 0;
`endif
  localparam int N       = L * 32 + 1;
  localparam int RST_REC = (L > 1) ? 40 : 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_ready, busy, done;
  logic [7:0] cfg_out;

  always #5 clk = ~clk;

  cfg_streamer #(.NUM_LAYERS(L)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .cfg_out(cfg_out), .busy(busy), .done(done)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  bit tr_on = 1'b0;
  logic [7:0] tr_cfg[$];
  bit         tr_busy[$];
  bit         tr_done[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, got, want);
    end
  endtask

  // ---------------- record-level model ----------------
  bit         m_active, m_owe, m_gap;
  int         m_rec;
  logic [7:0] m_pay;
  logic [7:0] exp_cfg = 8'h00;
  bit         exp_busy, exp_done;

  function automatic logic [7:0] hdr(input int r);
    if (r == N - 1) return 8'h7F;
    return 8'h80 | 8'(r);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_active = 0; m_owe = 0; m_gap = 0; m_rec = 0;
      exp_cfg = 8'h00; exp_busy = 0; exp_done = 0;
    end else begin
      exp_cfg  = 8'h00;
      exp_done = 0;
      if (!m_active) begin
        if (start && !abort) begin m_active = 1; m_rec = 0; end
      end else if (m_owe) begin
        exp_cfg = m_pay;
        m_owe   = 0;
        if (m_rec == N - 1) begin m_active = 0; exp_done = !abort; end
        else if (abort) m_active = 0;
        else begin m_rec++; m_gap = (GAPC != 0); end
      end else if (m_gap) begin
        m_gap = 0;
        if (abort) m_active = 0;
      end else if (abort) begin
        m_active = 0;
      end else if (s_valid) begin
        exp_cfg = hdr(m_rec);
        m_pay   = s_data;
        m_owe   = 1;
      end
      exp_busy = m_active;
    end
  end

  // ---------------- per-cycle compare + trace ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cfg_out", cfg_out, exp_cfg);
      chk("busy", busy, exp_busy);
      chk("done", done, exp_done);
      chk("s_ready", s_ready, m_active && !m_owe && !m_gap && !abort);
    end
    if (tr_on) begin
      tr_cfg.push_back(cfg_out);
      tr_busy.push_back(busy);
      tr_done.push_back(done);
    end
  end

  // ---------------- trace helpers ----------------
  function automatic int find(input logic [7:0] v, input int from);
    for (int i = (from < 0 ? 0 : from); i < tr_cfg.size(); i++)
      if (tr_cfg[i] === v) return i;
    return -1;
  endfunction

  function automatic int first_nz();
    for (int i = 0; i < tr_cfg.size(); i++) if (tr_cfg[i] !== 8'h00) return i;
    return -1;
  endfunction

  function automatic int nz_after(input int from);
    int c = 0;
    for (int i = from + 1; i < tr_cfg.size(); i++) if (tr_cfg[i] !== 8'h00) c++;
    return c;
  endfunction

  function automatic int done_cnt();
    int c = 0;
    foreach (tr_done[i]) if (tr_done[i]) c++;
    return c;
  endfunction

  function automatic int done_at();
    foreach (tr_done[i]) if (tr_done[i]) return i;
    return -1;
  endfunction

  function automatic int busy_low(input int a, input int b);
    int c = 0;
    for (int i = a; i <= b && i < tr_busy.size(); i++) if (!tr_busy[i]) c++;
    return c;
  endfunction

  // One pass: start, feed payloads (k, or ovr_val at record ovr_rec), stall
  // stall_len ready cycles before record stall_rec, abort abort_dly cycles
  // after the handshake of abort_rec, reset in DATA of rst_rec, and poke
  // start again at loop cycle poke_cyc.
  task automatic run_pass(input int stall_rec, input int stall_len,
                          input int abort_rec, input int abort_dly,
                          input int rst_rec, input int ovr_rec,
                          input logic [7:0] ovr_val, input int poke_cyc);
    int k = 0;
    int stall_left = stall_len;
    int ab_cnt = -1;
    bit hs;
    bit fin = 0;
    @(posedge clk); #1;
    tr_cfg.delete(); tr_busy.delete(); tr_done.delete();
    tr_on = 1;
    start = 1; s_valid = 0;
    @(posedge clk); #1;
    start = 0;
    for (int c = 0; c < 1000 && !fin; c++) begin
      s_valid = !(k == stall_rec && stall_left > 0);
      s_data  = (k == ovr_rec) ? ovr_val : 8'(k);
      start   = (c == poke_cyc);
      @(negedge clk);
      hs = s_valid && s_ready;
      if (!s_valid && s_ready) stall_left--;
      @(posedge clk); #1;
      abort = 0; rst_n = 1;
      if (hs && k == abort_rec) ab_cnt = abort_dly;
      if (hs && k == rst_rec) rst_n = 0;
      if (ab_cnt == 0) begin abort = 1; ab_cnt = -1; end
      else if (ab_cnt > 0) ab_cnt--;
      if (hs) k++;
      fin = !m_active && rst_n;
    end
    chk("pass_end", fin, 1);
    start = 0; abort = 0; s_valid = 0; rst_n = 1;
    repeat (4) @(posedge clk);
    #1 tr_on = 0;
  endtask

  initial begin
    int f, d, p, i1, h2, h;
    // reset
    rst_n = 0;
    @(posedge clk); #1 chk_en = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_cfg", cfg_out, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", s_ready, 0);
    // start together with abort is ignored
    @(posedge clk); #1 start = 1; abort = 1;
    @(posedge clk); #1 start = 0; abort = 0;
    @(negedge clk);
    chk("start_abort_busy", busy, 0);

    // P1: full pass, source always valid, stray start mid-pass
    run_pass(-1, 0, -1, 0, -1, -1, 8'h00, 20);
    f = find(8'h80, 0);
    d = done_at();
    chk("p1_first_pos", f, 2);
    chk("p1_busy_at_start", tr_busy[1], 1);
    chk("p1_done_cnt", done_cnt(), 1);
    chk("p1_busy_through", busy_low(1, d - 1), 0);
    chk("p1_busy_fall", tr_busy[d], 0);
`ifdef CFG_STREAMER_GAP_EN
    chk("p1_b1", tr_cfg[f+1], 8'h00);
    chk("p1_b2", tr_cfg[f+2], 8'h00);
    chk("p1_b3", tr_cfg[f+3], 8'h81);
    chk("p1_b4", tr_cfg[f+4], 8'h01);
    chk("p1_len", d - f + 1, 98);
    chk("p1_last_hdr", tr_cfg[d-4], 8'h9F);
    chk("p1_last_pay", tr_cfg[d-3], 8'h1F);
    chk("p1_gap", tr_cfg[d-2], 8'h00);
    chk("p1_mask_hdr", tr_cfg[d-1], 8'h7F);
    chk("p1_mask_pay", tr_cfg[d], 8'h20);
`else
    chk("p1_b1", tr_cfg[f+1], 8'h00);
    chk("p1_b2", tr_cfg[f+2], 8'h81);
    chk("p1_b3", tr_cfg[f+3], 8'h01);
    chk("p1_len", d - f + 1, 258);
    chk("p1_last_hdr", tr_cfg[d-3], 8'hFF);
    chk("p1_last_pay", tr_cfg[d-2], 8'h7F);
    chk("p1_mask_hdr", tr_cfg[d-1], 8'h7F);
    chk("p1_mask_pay", tr_cfg[d], 8'h80);
`endif

    // P2: 0x7F payload at idx 5, 3-cycle stall before record 2, abort in DATA of idx 10
    run_pass(2, 3, 10, 0, -1, 5, 8'h7F, -1);
    p = find(8'h85, 0);
    chk("p2_7f_pay", tr_cfg[p+1], 8'h7F);
    chk("p2_next_hdr", find(8'h86, p) - p, 2 + GAPC);
    i1 = find(8'h81, 0);
    h2 = find(8'h82, 0);
    chk("p2_pay1", tr_cfg[i1+1], 8'h01);
    chk("p2_stall_zeros", h2 - i1 - 2, 3 + GAPC);
    h = find(8'h8A, 0);
    chk("p2_abort_pay", tr_cfg[h+1], 8'h0A);
    chk("p2_abort_quiet", nz_after(h + 1), 0);
    chk("p2_no_done", done_cnt(), 0);
    chk("p2_busy_end", tr_busy[tr_busy.size()-1], 0);

    // P3: abort while waiting for record 4, source valid
    run_pass(-1, 0, 3, 1 + GAPC, -1, -1, 8'h00, -1);
    h = find(8'h83, 0);
    chk("p3_pay3", tr_cfg[h+1], 8'h03);
    chk("p3_no_hdr4", find(8'h84, 0), -1);
    chk("p3_quiet", nz_after(h + 1), 0);
    chk("p3_no_done", done_cnt(), 0);

    // P4: reset in DATA of RST_REC
    run_pass(-1, 0, -1, 0, RST_REC, -1, 8'h00, -1);
    h = find(8'h80 | 8'(RST_REC), 0);
    chk("p4_rst_cfg", tr_cfg[h+1], 8'h00);
    chk("p4_rst_busy", tr_busy[h+1], 0);
    chk("p4_no_done", done_cnt(), 0);

    // P5: restart after reset begins at header 0x80
    run_pass(-1, 0, 2, 0, -1, -1, 8'h00, -1);
    h = first_nz();
    chk("p5_first_pos", h, 2);
    chk("p5_first_hdr", tr_cfg[h], 8'h80);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/cfg_streamer.md
# cfg_streamer

Transmit-side counterpart of the fabric's per-unit configuration port. The block takes a linear stream of configuration payload bytes from a valid/ready source, which is the bitstream loader. It serialises them onto the 8-bit `cfg_out` bus as header/payload byte pairs that the logic unit's configuration decoder consumes. It generates every header itself, so the source supplies payloads only, in a fixed order. It sits between the bitstream loader and the `cfg_in` port of one unit.

## Interface
Parameters:
- `NUM_LAYERS`, default 4: number of logic layers to configure, legal range 1–4.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low; clock `clk`.
- `start` in 1: begin a configuration pass. Sampled in IDLE only.
- `abort` in 1: terminate the pass at the next record boundary.
- `s_data` in 8: payload byte from the source.
- `s_valid` in 1: `s_data` is valid.
- `s_ready` out 1: payload accepted when `s_valid && s_ready` at a rising edge.
- `cfg_out` out 8: registered byte stream to the unit's `cfg_in`.
- `busy` out 1: registered. High while a pass is in progress.
- `done` out 1: registered. One-cycle pulse at the end of a pass that ran to completion.

## Operation
- Record = header byte, then payload byte on the next cycle. The two are never separated.
- Idle byte is 0x00. Any cycle that carries neither a header nor a payload drives 0x00.
- Block records: record index `idx` counts 0 … `NUM_LAYERS`*32−1. Header = {1'b1, idx[6:0]}:
  - idx[6:5] = layer
  - idx[4:2] = bit address
  - idx[1:0] = field select (0 = X, 1 = Y, 2 = AB, 3 = CX)
  - Order: layer-major, then bit address, then field.
- Final record: header 0x7F, then the payload. This payload is the output-inversion mask.
- Total records per pass: N = `NUM_LAYERS`*32+1. N = 129 at the default.
- Payload bytes are forwarded unmodified. Any value is legal, including values with bit 7 set and 0x7F.
- FSM states:
  - IDLE: `s_ready`=0, `cfg_out`←0x00. On `start`, go to ISSUE with `idx`←0.
  - ISSUE: `s_ready`=1 combinationally.
    - On handshake: `cfg_out`←header, latch `s_data`, go to DATA.
    - Without handshake: `cfg_out`←0x00 and stay in ISSUE.
  - DATA: `s_ready`=0, `cfg_out`←latched payload.
    - If this was the mask record: go to IDLE and pulse `done`.
    - Otherwise: increment `idx` and go to ISSUE (or GAP, see Configuration).
- `abort`:
  - Sampled in ISSUE: go to IDLE immediately. No handshake occurs that cycle, even if `s_valid`=1.
  - Sampled in DATA: the payload is still emitted, then the block goes to IDLE.
  - An aborted pass never pulses `done`.
  - `abort` together with `start` in IDLE: `start` is ignored.
- `start` outside IDLE is ignored.
- Reset mid-pass: state is discarded. `cfg_out` is 0x00 from the first cycle after the reset edge. A truncated record may be seen by the receiver. The loader must re-run the pass after reset.

## Timing
- Reset values: `cfg_out`=0x00, `busy`=0, `done`=0, `s_ready`=0, state IDLE, `idx`=0.
- `start` sampled high at edge E:
  - `busy`=1 and `s_ready`=1 from E.
  - The first header appears at the edge after the first handshake.
- Handshake at edge K: header is visible after K, payload is visible after K+1.
- Peak throughput: one record every 2 cycles, with the source holding `s_valid` high.
- Minimum pass length: 2N cycles from the first handshake. That is 258 at the default.
- `busy` falls, and `done` pulses for one cycle, at the same edge that drives the mask payload.
- Source stall: 0x00 is inserted between records, never inside a record.

## Configuration
- `CFG_STREAMER_GAP_EN`:
  - Defined: the FSM goes DATA → GAP → ISSUE after every non-final record. GAP drives 0x00 with `s_ready`=0 for exactly one cycle. Peak throughput becomes 1 record per 3 cycles. This guarantees the receiver one idle cycle between records.
  - Undefined: there is no GAP state and records are back-to-back, 2 cycles each.

## Test plan
- Full pass, `NUM_LAYERS`=4, `s_valid` always 1, payload k = k[7:0]:
  - `cfg_out` sequence is 0x80, 0x00, 0x81, 0x01, … 0xFF, 0x7F, then 0x7F, 0x80.
  - `done` pulses exactly once, 258 cycles after the first handshake.
  - `busy` is high throughout.
- Payload 0x7F sent at idx 5: 0x85 is followed by 0x7F with no state disturbance. The next header is 0x86.
- Source stalls 3 cycles before record 2: exactly three 0x00 bytes appear between payload 1 and header 0x82. `s_ready` stays high during the stall.
- Abort:
  - `abort` in DATA of idx 10: payload emitted, then 0x00 forever, `busy` 0, no `done`.
  - `abort` in ISSUE: no further header.
- Reset at idx 40 while in DATA: `cfg_out`=0x00 and `busy`=0 the cycle after reset. A new `start` restarts at header 0x80.
- `NUM_LAYERS`=1 with `CFG_STREAMER_GAP_EN`: 33 records. The last block header is 0x9F, followed by 0x7F. 0x00 appears between every record. Pass takes 3·32+2 = 98 cycles.
